// File: rtl/spectrum_bar_if.sv
// spectrum_bar_if: valid/ready stream of complex FFT bins feeding the bar scheduler
interface spectrum_bar_if #(parameter int BIN_W = 36);
   logic bin_valid;
   logic bin_ready;
   logic bin_last;
   logic [BIN_W-1:0] bin_data;
   modport master(output bin_valid, bin_data, bin_last, input bin_ready);
   modport slave(input bin_valid, bin_data, bin_last, output bin_ready);
endinterface

// File: rtl/spectrum_bar_scheduler.sv
// spectrum_bar_scheduler: collects one frame of FFT bins as bar heights and commits them with peak-hold decay at vblank
module spectrum_bar_scheduler #(
   parameter int NUM_BINS = 16,
   parameter int BIN_W = 36,
   parameter int H_W = 10,
   parameter int MAX_HEIGHT = 480,
   parameter int SCALE_SHIFT = 8,
   parameter int DECAY = 4
) (
   input logic clk,
   input logic rst_n,
   spectrum_bar_if.slave s,
   input logic vblank,
   output logic [H_W-1:0] heights [0:NUM_BINS-1],
   output logic frame_tick,
   output logic sync_err,
   output logic [7:0] drop_count
);
   localparam int C_W = BIN_W / 2;
   localparam int A_W = C_W + 1;
   localparam int I_W = $clog2(NUM_BINS);
   typedef enum logic [1:0] {COLLECT, FULL, COMMIT} state_t;
   state_t state;
   logic [I_W-1:0] idx;
   logic [H_W-1:0] shadow [0:NUM_BINS-1];
   logic [H_W-1:0] next_h [0:NUM_BINS-1];
   logic [NUM_BINS-1:0] written;
   logic vblank_q;
   logic [C_W-1:0] re, im, re_abs, im_abs;
   logic [A_W-1:0] a, m;
   logic [H_W-1:0] mag;
   logic acc, vb_rise, at_end;
   function automatic logic [H_W-1:0] decay(input logic [H_W-1:0] h);
      return h > H_W'(DECAY) ? h - H_W'(DECAY) : '0;
   endfunction
   // unsigned abs of the most negative value is exact in C_W bits
   always_comb begin
      re = s.bin_data[BIN_W-1:C_W];
      im = s.bin_data[C_W-1:0];
      re_abs = re[C_W-1] ? -re : re;
      im_abs = im[C_W-1] ? -im : im;
      a = A_W'(re_abs) + A_W'(im_abs);
      m = a >> SCALE_SHIFT;
      mag = m > A_W'(MAX_HEIGHT) ? H_W'(MAX_HEIGHT) : m[H_W-1:0];
      acc = s.bin_valid && s.bin_ready;
      vb_rise = vblank && !vblank_q;
      at_end = idx == I_W'(NUM_BINS - 1);
      for (int i = 0; i < NUM_BINS; i++)
         next_h[i] = written[i] && shadow[i] > decay(heights[i]) ? shadow[i] : decay(heights[i]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
         idx <= '0;
         written <= '0;
         vblank_q <= 1'b0;
         s.bin_ready <= 1'b0;
         frame_tick <= 1'b0;
         sync_err <= 1'b0;
         drop_count <= '0;
         for (int i = 0; i < NUM_BINS; i++) begin
            shadow[i] <= '0;
            heights[i] <= '0;
         end
      end else begin
         vblank_q <= vblank;
         frame_tick <= 1'b0;
         sync_err <= 1'b0;
         case (state)
            COLLECT: begin
               s.bin_ready <= !(acc && (s.bin_last || at_end));
               if (vb_rise && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
               if (acc) begin
                  shadow[idx] <= mag;
                  written[idx] <= 1'b1;
                  idx <= idx + I_W'(1);
                  if (s.bin_last || at_end) begin
                     state <= FULL;
                     sync_err <= s.bin_last != at_end;
                  end
               end
            end
            FULL: if (vb_rise) state <= COMMIT;
            COMMIT: begin
               for (int i = 0; i < NUM_BINS; i++) heights[i] <= next_h[i];
               frame_tick <= 1'b1;
               idx <= '0;
               written <= '0;
               state <= COLLECT;
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_spectrum_bar_scheduler.sv
// tb_spectrum_bar_scheduler: randomized scoreboard bench with a frame-level reference model
module tb_spectrum_bar_scheduler;
   localparam int NB = 16;
   localparam int HW = 10;
   localparam int MAXH = 480;
   localparam int SH = 8;
   localparam int DEC = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic vblank = 1'b0;
   logic [HW-1:0] heights [0:NB-1];
   logic frame_tick, sync_err;
   logic [7:0] drop_count;
   int tests = 0, fails = 0, sync_cnt = 0, exp_sync = 0, mdl_drop = 0;
   int mh [NB];
   int msh [NB];
   bit mw [NB];
   logic [35:0] fd [NB];
   logic [NB*HW-1:0] exp_q [$];
   spectrum_bar_if #(.BIN_W(36)) bus ();
   spectrum_bar_scheduler dut (
      .clk(clk), .rst_n(rst_n), .s(bus), .vblank(vblank), .heights(heights),
      .frame_tick(frame_tick), .sync_err(sync_err), .drop_count(drop_count)
   );
   always #5 clk = ~clk;
   function automatic logic [NB*HW-1:0] pack_model();
      logic [NB*HW-1:0] v = '0;
      for (int i = 0; i < NB; i++) v[i*HW +: HW] = HW'(mh[i]);
      return v;
   endfunction
   function automatic logic [NB*HW-1:0] pack_dut();
      logic [NB*HW-1:0] v = '0;
      for (int i = 0; i < NB; i++) v[i*HW +: HW] = heights[i];
      return v;
   endfunction
   function automatic int mag_of(input logic [35:0] d);
      int re = int'($signed(d[35:18]));
      int im = int'($signed(d[17:0]));
      int q = ((re < 0 ? -re : re) + (im < 0 ? -im : im)) / (1 << SH);
      return q > MAXH ? MAXH : q;
   endfunction
   function automatic logic [35:0] mk(input int re, input int im);
      return {18'(re), 18'(im)};
   endfunction
   task automatic chk(input string nm, input logic [NB*HW-1:0] got, input logic [NB*HW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (sync_err) sync_cnt++;
         if (frame_tick) begin
            if (exp_q.size() == 0) chk("unexpected_frame_tick", frame_tick, 0);
            else chk("heights_at_commit", pack_dut(), exp_q.pop_front());
         end
      end
   endtask
   task automatic beat(input logic [35:0] d, input logic last, input int gap);
      int t = 0;
      bus.bin_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.bin_valid = 1'b1;
      bus.bin_data = d;
      bus.bin_last = last;
      while (!bus.bin_ready && t < 64) begin
         @(negedge clk);
         t++;
      end
      if (t >= 64) chk("bin_ready_timeout", bus.bin_ready, 1);
      @(negedge clk);
      bus.bin_valid = 1'b0;
      bus.bin_last = 1'b0;
   endtask
   task automatic send_frame(input int k0, input int n, input int last_at, input int gmax);
      logic last;
      for (int k = k0; k < n; k++) begin
         last = k == last_at;
         beat(fd[k], last, gmax == 0 ? 0 : int'($urandom_range(0, gmax)));
         msh[k] = mag_of(fd[k]);
         mw[k] = 1'b1;
         if (last || k == NB - 1) begin
            if (last != (k == NB - 1)) exp_sync++;
            break;
         end
      end
   endtask
   task automatic vsync();
      int old;
      @(negedge clk);
      chk("sync_err_count", sync_cnt, exp_sync);
      for (int i = 0; i < NB; i++) begin
         old = mh[i] - DEC < 0 ? 0 : mh[i] - DEC;
         mh[i] = mw[i] && msh[i] > old ? msh[i] : old;
         mw[i] = 1'b0;
      end
      exp_q.push_back(pack_model());
      vblank = 1'b1;
      @(negedge clk);
      chk("tick_not_at_E", frame_tick, 0);
      @(negedge clk);
      chk("tick_at_E_plus_1", frame_tick, 1);
      vblank = 1'b0;
   endtask
   task automatic pulse_vb();
      @(negedge clk);
      vblank = 1'b1;
      mdl_drop++;
      repeat (2) @(negedge clk);
      vblank = 1'b0;
   endtask
   task automatic rand_fill();
      for (int k = 0; k < NB; k++)
         fd[k] = mk(int'($urandom_range(0, 140000)) - 70000, int'($urandom_range(0, 140000)) - 70000);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end
   initial begin
      logic rdy_seen;
      int la;
      bus.bin_valid = 1'b0;
      bus.bin_data = '0;
      bus.bin_last = 1'b0;
      for (int i = 0; i < NB; i++) begin
         mh[i] = 0;
         msh[i] = 0;
         mw[i] = 1'b0;
      end
      fork monitor(); join_none
      #2;
      chk("reset_heights", pack_dut(), '0);
      chk("reset_bin_ready", bus.bin_ready, 0);
      chk("reset_pulses", {frame_tick, sync_err}, 0);
      chk("reset_drop_count", drop_count, 0);
      #10 rst_n = 1'b1;
      @(negedge clk);
      chk("bin_ready_after_reset", bus.bin_ready, 1);
      for (int k = 0; k < NB; k++) fd[k] = mk(25600, 0);
      send_frame(0, NB, NB - 1, 0);
      vsync();
      for (int f = 0; f < 25; f++) begin
         for (int k = 0; k < NB; k++) fd[k] = '0;
         send_frame(0, NB, NB - 1, 1);
         vsync();
      end
      chk("decayed_to_zero", pack_dut(), '0);
      rand_fill();
      fd[0] = mk(-131072, -131072);
      fd[1] = mk(131071, 0);
      send_frame(0, NB, NB - 1, 0);
      vsync();
      rand_fill();
      send_frame(0, 5, 4, 0);
      vsync();
      rand_fill();
      send_frame(0, NB, -1, 0);
      rdy_seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         rdy_seen |= bus.bin_ready;
      end
      chk("bin_ready_low_in_full", rdy_seen, 0);
      vsync();
      rand_fill();
      send_frame(0, 4, -1, 3);
      pulse_vb();
      send_frame(4, 9, -1, 3);
      pulse_vb();
      chk("drop_count_two", drop_count, mdl_drop);
      chk("heights_hold_on_drop", pack_dut(), pack_model());
      send_frame(9, NB, NB - 1, 3);
      vsync();
      rand_fill();
      send_frame(0, NB - 1, -1, 0);
      vblank = 1'b1;
      mdl_drop++;
      send_frame(NB - 1, NB, NB - 1, 0);
      repeat (4) @(negedge clk);
      vblank = 1'b0;
      chk("drop_count_held_vblank", drop_count, mdl_drop);
      vsync();
      repeat (6) begin
         rand_fill();
         la = int'($urandom_range(0, 19));
         send_frame(0, NB, la > NB - 1 ? -1 : la, 3);
         vsync();
      end
      rand_fill();
      send_frame(0, 7, -1, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_heights", pack_dut(), '0);
      chk("async_reset_bin_ready", bus.bin_ready, 0);
      for (int i = 0; i < NB; i++) begin
         mh[i] = 0;
         mw[i] = 1'b0;
      end
      mdl_drop = 0;
      #9 rst_n = 1'b1;
      @(negedge clk);
      chk("drop_count_after_reset", drop_count, mdl_drop);
      rand_fill();
      send_frame(0, NB, NB - 1, 1);
      vsync();
      repeat (3) @(negedge clk);
      chk("pending_commits", exp_q.size(), 0);
      chk("sync_err_total", sync_cnt, exp_sync);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
